// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit.
// Opcode/funct fields, FSM states and default width.
package mips_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide.
// Operates on magnitudes; sign correction happens in the top.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem,
  output logic              last
);

  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  b_r;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    sum;
  logic [XLEN:0]    shifted;
  logic             ge;

  assign last = (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    sum     = {1'b0, prod[2*XLEN-1:XLEN]}
            + {1'b0, (prod[0] ? a_r : '0)};
    shifted = {rem, quo[XLEN-1]};
    ge      = (shifted >= {1'b0, b_r});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      cnt  <= '0;
      prod <= '0;
      quo  <= '0;
      rem  <= '0;
    end else if (start) begin
      a_r  <= a;
      b_r  <= b;
      cnt  <= '0;
      prod <= {{XLEN{1'b0}}, b};
      quo  <= a;
      rem  <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (div_mode) begin
        // Partial remainder stays below the divisor, so XLEN bits suffice.
        rem <= ge ? XLEN'(shifted - {1'b0, b_r})
                  : shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ge};
      end else begin
        prod <= {sum, prod[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit with HI/LO and pipeline interlock.
// Decode, FSM, sign fix and HI/LO live here; iteration in muldiv_iter.
module ex_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            flush,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] hilo_rd,
  output logic            rd_valid,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t state;

  logic is_mf, is_mt, is_mdu;
  logic is_sgn, is_div, sel_hi;
  logic req, go, start, run;
  logic sa, sb, neg_r, sa_r, dz_r;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [2*XLEN-1:0] prod, p_fix;
  logic [XLEN-1:0] quo, rem, q_fix, r_fix;
  logic [XLEN-1:0] fix_hi, fix_lo;
  logic last;
  logic unused;

  assign unused = ^inst[25:6];

  always_comb begin
    is_mf  = 1'b0;
    is_mt  = 1'b0;
    is_mdu = 1'b0;
    is_sgn = 1'b0;
    is_div = 1'b0;
    sel_hi = 1'b0;
    if (inst[31:26] == OP_SPECIAL) begin
      case (inst[5:0])
        FN_MFHI:  begin is_mf = 1'b1; sel_hi = 1'b1; end
        FN_MTHI:  begin is_mt = 1'b1; sel_hi = 1'b1; end
        FN_MFLO:  is_mf = 1'b1;
        FN_MTLO:  is_mt = 1'b1;
        FN_MULT:  begin is_mdu = 1'b1; is_sgn = 1'b1; end
        FN_MULTU: is_mdu = 1'b1;
        FN_DIV:   begin is_mdu = 1'b1; is_sgn = 1'b1; is_div = 1'b1; end
        FN_DIVU:  begin is_mdu = 1'b1; is_div = 1'b1; end
        default:  ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign req      = ex_valid & ~flush & (is_mf | is_mt | is_mdu);
  assign stall    = req & busy;
  assign go       = req & ~busy;
  assign start    = go & is_mdu;
  assign rd_valid = go & is_mf;
  assign hilo_rd  = rd_valid ? (sel_hi ? hi : lo) : '0;
  assign run      = (state == S_MUL) | (state == S_DIV);

  assign sa    = is_sgn & rs_val[XLEN-1];
  assign sb    = is_sgn & rt_val[XLEN-1];
  assign mag_a = sa ? -rs_val : rs_val;
  assign mag_b = sb ? -rt_val : rt_val;

  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .run      (run),
    .div_mode (state == S_DIV),
    .a        (mag_a),
    .b        (mag_b),
    .prod     (prod),
    .quo      (quo),
    .rem      (rem),
    .last     (last)
  );

  // Divide by zero forces an all-ones quotient regardless of sign.
  always_comb begin
    p_fix = neg_r ? -prod : prod;
    q_fix = neg_r ? -quo : quo;
    r_fix = sa_r ? -rem : rem;
    if (state == S_DIV || state == S_FIX && dz_r) begin
      fix_hi = r_fix;
      fix_lo = dz_r ? '1 : q_fix;
    end else begin
      fix_hi = p_fix[2*XLEN-1:XLEN];
      fix_lo = p_fix[XLEN-1:0];
    end
  end

  logic op_div_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hi       <= '0;
      lo       <= '0;
      neg_r    <= 1'b0;
      sa_r     <= 1'b0;
      dz_r     <= 1'b0;
      op_div_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= is_div ? S_DIV : S_MUL;
            neg_r    <= sa ^ sb;
            sa_r     <= sa;
            dz_r     <= is_div & (rt_val == '0);
            op_div_r <= is_div;
          end else if (go & is_mt) begin
            if (sel_hi) hi <= rs_val;
            else        lo <= rs_val;
          end
        end
        S_MUL, S_DIV: begin
          if (last) state <= S_FIX;
        end
        S_FIX: begin
          hi    <= op_div_r ? r_fix : fix_hi;
          lo    <= op_div_r ? (dz_r ? '1 : q_fix) : fix_lo;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed MULT/DIV/MT/MF vectors.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] rs_val = 32'h0;
  logic [31:0] rt_val = 32'h0;
  logic        stall, busy, rd_valid;
  logic [31:0] hilo_rd, hi, lo;

  int passed = 0;
  int total  = 0;
  int last_stall = 0;

  logic [63:0] exp_hl[$];
  logic [31:0] exp_rd[$];

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20;

  ex_muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .flush    (flush),
    .inst     (inst),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .stall    (stall),
    .busy     (busy),
    .hilo_rd  (hilo_rd),
    .rd_valid (rd_valid),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {26'h0, fn};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic issue(input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    int n;
    n = 0;
    ex_valid = 1'b1;
    inst = rtype(fn);
    rs_val = a;
    rt_val = b;
    flush = fl;
    @(negedge clk);
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("issue_timeout", 32'(n), 32'd0);
    last_stall = n;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    flush = 1'b0;
    inst = 32'h0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic muldiv(input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] e);
    exp_hl.push_back(e);
    issue(fn, a, b, 1'b0);
    wait_idle();
  endtask

  task automatic rd(input logic [5:0] fn, input logic [31:0] e);
    exp_rd.push_back(e);
    issue(fn, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin : monitor
    int bcnt;
    logic prev;
    logic [63:0] e;
    bcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
        prev = 1'b0;
      end else begin
        if (rd_valid) begin
          if (exp_rd.size() == 0) check("rd_unexpected", hilo_rd, 32'hx);
          else check("hilo_rd", hilo_rd, exp_rd.pop_front());
        end
        if (busy) bcnt++;
        else if (prev) begin
          check("busy_cycles", 32'(bcnt), 32'd33);
          bcnt = 0;
          if (exp_hl.size() == 0) check("done_unexpected", hi, 32'hx);
          else begin
            e = exp_hl.pop_front();
            check("hi", hi, e[63:32]);
            check("lo", lo, e[31:0]);
          end
        end
        prev = busy;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_hilo_rd", hilo_rd, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    muldiv(F_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    rd(F_MFHI, 32'hFFFF_FFFF);
    rd(F_MFLO, 32'hFFFF_FFEB);

    muldiv(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001);
    muldiv(F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);

    exp_hl.push_back(64'h0000_0000_0000_001E);
    issue(F_MULT, 32'd5, 32'd6, 1'b0);
    rd(F_MFLO, 32'h0000_001E);
    check("mflo_stalled", 32'(last_stall >= 32), 32'd1);

    muldiv(F_DIVU, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF);
    muldiv(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000);
    muldiv(F_DIV, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF);

    issue(F_MTLO, 32'h0000_ABCD, 32'h0, 1'b0);
    rd(F_MFLO, 32'h0000_ABCD);

    exp_hl.push_back(64'h0000_0000_0000_0006);
    issue(F_MULT, 32'd2, 32'd3, 1'b0);
    issue(F_MTHI, 32'h0000_0055, 32'h0, 1'b0);
    rd(F_MFHI, 32'h0000_0055);
    rd(F_MFLO, 32'h0000_0006);

    issue(F_MULT, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", hi, 32'h0000_0055);
    check("flush_lo", lo, 32'h0000_0006);
    @(posedge clk);
    #1;

    exp_hl.push_back(64'h0000_0002_0000_000E);
    issue(F_DIV, 32'd100, 32'd7, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    issue(F_MFHI, 32'h0, 32'h0, 1'b1);
    wait_idle();

    exp_hl.push_back(64'h0000_0000_0000_000C);
    issue(F_MULT, 32'd3, 32'd4, 1'b0);
    ex_valid = 1'b1;
    inst = rtype(F_ADD);
    @(negedge clk);
    check("add_busy", 32'(busy), 32'd1);
    check("add_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    inst = 32'h0;
    wait_idle();

    issue(F_MULT, 32'd11, 32'd13, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    ex_valid = 1'b1;
    inst = rtype(F_MFLO);
    @(negedge clk);
    check("pre_rst_stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    inst = 32'h0;
    rd(F_MFLO, 32'h0);

    repeat (40) @(posedge clk);
    #1;
    check("hl_queue_empty", 32'(exp_hl.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
